// File: rtl/flow_sched_pkg.sv
// Shared types for the flow scheduler: flow state, tag width helper and the
// decoded configuration word.
package flow_sched_pkg;

  typedef enum logic {StIdle, StActive} flow_state_e;

  // Upper bounds for the decoded cfg fields; real widths come from the
  // instantiating module and are zero-extended into these.
  localparam int unsigned CfgTagMaxW  = 16;
  localparam int unsigned CfgSizeMaxW = 16;

  typedef struct packed {
    logic [CfgTagMaxW-1:0]  tag;
    logic [CfgSizeMaxW-1:0] ext_size;
  } cfg_t;

  // Tag width for a given flow count; a single flow still carries a 1-bit tag.
  function automatic int unsigned tag_w(input int unsigned flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: grants the first requester at or after ptr_i (wrapping).
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned PtrW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o
);

  logic [PtrW-1:0] idx;
  logic            found;

  // Walk requesters starting at the pointer; first hit wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PtrW'((32'(ptr_i) + i) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flow_scheduler.sv
// Multiplexes FLUX pixel flows onto one shared filter input with round-robin
// arbitration. Each flow runs ext_size*ext_size pixels per configuration.
// Optional stall/grant counters are built when FLOW_SCHED_STATS_EN is defined.
module flow_scheduler
  import flow_sched_pkg::*;
#(
  parameter int unsigned FLUX   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SIZE_W = 7,
  localparam int unsigned TAG_W = tag_w(FLUX)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_write,
  input  logic [TAG_W+SIZE_W-1:0]  cfg_din,
  input  logic [FLUX-1:0]          in_valid,
  input  logic [FLUX*DATA_W-1:0]   in_data,
  output logic [FLUX-1:0]          in_ready,
  output logic [TAG_W+DATA_W-1:0]  out_din,
  output logic                     out_write,
  input  logic [FLUX-1:0]          out_full,
  output logic [FLUX-1:0]          flow_done,
  output logic                     cfg_err
`ifdef FLOW_SCHED_STATS_EN
  ,
  output logic [FLUX*32-1:0]       stall_cnt,
  output logic [FLUX*32-1:0]       grant_cnt
`endif
);

  localparam int unsigned RemW = 2 * SIZE_W;

  flow_state_e             state_q [FLUX];
  flow_state_e             state_d [FLUX];
  logic [RemW-1:0]         rem_q   [FLUX];
  logic [RemW-1:0]         rem_d   [FLUX];
  logic [TAG_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [FLUX-1:0]         issued_q;  // grant vector of the previous cycle
  logic                    out_write_q, out_write_d;
  logic [TAG_W+DATA_W-1:0] out_din_q, out_din_d;
  logic [FLUX-1:0]         flow_done_q, flow_done_d;
  logic                    cfg_err_q, cfg_err_d;

  logic [FLUX-1:0]         eligible, gnt;
  logic [TAG_W-1:0]        gnt_idx;
  logic [DATA_W-1:0]       gnt_data;
  cfg_t                    cfg;
  logic [TAG_W-1:0]        cfg_tag;
  logic [SIZE_W-1:0]       cfg_size;
  logic                    cfg_ok;

  // A flow may be granted only if active, offering data, not back-pressured
  // and not issued last cycle.
  always_comb begin
    eligible = '0;
    for (int unsigned f = 0; f < FLUX; f++) begin
      eligible[f] = (state_q[f] == StActive) && in_valid[f] && !out_full[f] && !issued_q[f];
    end
  end

  rr_arbiter #(
    .N    (FLUX),
    .PtrW (TAG_W)
  ) u_arb (
    .req_i (eligible),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt)
  );

  assign in_ready = gnt;

  // Encode the one-hot grant and select its pixel.
  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int unsigned f = 0; f < FLUX; f++) begin
      if (gnt[f]) begin
        gnt_idx  = TAG_W'(f);
        gnt_data = in_data[f*DATA_W +: DATA_W];
      end
    end
  end

  // Decode the cfg word; acceptance is judged on the state sampled this cycle.
  always_comb begin
    cfg.tag      = CfgTagMaxW'(cfg_din[SIZE_W +: TAG_W]);
    cfg.ext_size = CfgSizeMaxW'(cfg_din[SIZE_W-1:0]);
    cfg_tag      = cfg.tag[TAG_W-1:0];
    cfg_size     = cfg.ext_size[SIZE_W-1:0];
    cfg_ok       = (cfg_size != '0) && (32'(cfg_tag) < FLUX) && (state_q[cfg_tag] == StIdle);
  end

  // Next-state: grant bookkeeping, pointer advance, then configuration.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    rr_ptr_d    = rr_ptr_q;
    out_write_d = |gnt;
    out_din_d   = '0;
    flow_done_d = '0;
    cfg_err_d   = 1'b0;
    if (|gnt) begin
      out_din_d      = {gnt_idx, gnt_data};
      rem_d[gnt_idx] = rem_q[gnt_idx] - RemW'(1);
      if (rem_q[gnt_idx] == RemW'(1)) begin
        state_d[gnt_idx]     = StIdle;
        flow_done_d[gnt_idx] = 1'b1;
      end
      rr_ptr_d = (32'(gnt_idx) == FLUX - 1) ? '0 : gnt_idx + TAG_W'(1);
    end
    // Accepted cfg only targets an idle flow, so it never collides with a grant.
    if (cfg_write) begin
      if (cfg_ok) begin
        state_d[cfg_tag] = StActive;
        rem_d[cfg_tag]   = RemW'(cfg_size) * RemW'(cfg_size);
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  // State and registered output stage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned f = 0; f < FLUX; f++) begin
        state_q[f] <= StIdle;
        rem_q[f]   <= '0;
      end
      rr_ptr_q    <= '0;
      issued_q    <= '0;
      out_write_q <= 1'b0;
      out_din_q   <= '0;
      flow_done_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      rr_ptr_q    <= rr_ptr_d;
      issued_q    <= gnt;
      out_write_q <= out_write_d;
      out_din_q   <= out_din_d;
      flow_done_q <= flow_done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign out_write = out_write_q;
  assign out_din   = out_din_q;
  assign flow_done = flow_done_q;
  assign cfg_err   = cfg_err_q;

`ifdef FLOW_SCHED_STATS_EN
  logic [31:0] stall_q [FLUX];
  logic [31:0] stall_d [FLUX];
  logic [31:0] grant_q [FLUX];
  logic [31:0] grant_d [FLUX];

  // Count stalls and grants per flow; a new configuration restarts them.
  always_comb begin
    stall_d = stall_q;
    grant_d = grant_q;
    for (int unsigned f = 0; f < FLUX; f++) begin
      if (cfg_write && cfg_ok && (cfg_tag == TAG_W'(f))) begin
        stall_d[f] = '0;
        grant_d[f] = '0;
      end else begin
        if ((state_q[f] == StActive) && in_valid[f] && !gnt[f]) stall_d[f] = stall_q[f] + 32'd1;
        if (gnt[f]) grant_d[f] = grant_q[f] + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned f = 0; f < FLUX; f++) begin
        stall_q[f] <= '0;
        grant_q[f] <= '0;
      end
    end else begin
      stall_q <= stall_d;
      grant_q <= grant_d;
    end
  end

  // Flatten counters onto the output buses.
  always_comb begin
    stall_cnt = '0;
    grant_cnt = '0;
    for (int unsigned f = 0; f < FLUX; f++) begin
      stall_cnt[f*32 +: 32] = stall_q[f];
      grant_cnt[f*32 +: 32] = grant_q[f];
    end
  end
`endif

endmodule

// File: tb/tb_flow_scheduler.sv
// Scoreboard bench for flow_scheduler: a flow-level reference model predicts
// grants, writes and cfg errors; a negedge monitor checks the DUT outputs.
module tb_flow_scheduler;

  localparam int F  = 4;
  localparam int DW = 8;
  localparam int SW = 7;
  localparam int TW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_write = 1'b0;
  logic [TW+SW-1:0] cfg_din = '0;
  logic [F-1:0]    in_valid = '0;
  logic [F*DW-1:0] in_data = '0;
  logic [F-1:0]    out_full = '0;
  logic [F-1:0]    in_ready;
  logic [TW+DW-1:0] out_din;
  logic            out_write;
  logic [F-1:0]    flow_done;
  logic            cfg_err;

  always #5 clk = ~clk;

  flow_scheduler #(
    .FLUX   (F),
    .DATA_W (DW),
    .SIZE_W (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_write (cfg_write),
    .cfg_din   (cfg_din),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_din   (out_din),
    .out_write (out_write),
    .out_full  (out_full),
    .flow_done (flow_done),
    .cfg_err   (cfg_err)
  );

  typedef struct {
    logic [TW+DW-1:0] din;
    logic [F-1:0]     done;
  } wr_t;

  int  n_pass = 0;
  int  n_total = 0;
  wr_t exp_q[$];
  bit  err_q[$];

  // Reference model: per-flow activity and pixels left, last-issued flow, rotation start.
  bit  m_act[F];
  int  m_rem[F];
  bit  m_last[F];
  int  m_rr;

  int  wr_cnt[F];
  int  err_seen;
  int  cons_cnt;
  bit  prev_wr;
  bit  started;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail(input string msg);
    n_total++;
    $display("FAIL %s (t=%0t)", msg, $time);
  endtask

  function automatic bit model_idle();
    for (int f = 0; f < F; f++) if (m_act[f]) return 1'b0;
    return 1'b1;
  endfunction

  // One cycle of the reference model, evaluated on the inputs of the coming edge.
  task automatic model_cycle();
    int t, sz, g, f;
    bit ok;
    logic [F-1:0] rdy;
    wr_t w;
    if (rst) begin
      for (int k = 0; k < F; k++) begin
        m_act[k] = 0; m_rem[k] = 0; m_last[k] = 0;
      end
      m_rr = 0;
      err_q.push_back(1'b0);
      return;
    end
    t  = int'(cfg_din[SW+TW-1:SW]);
    sz = int'(cfg_din[SW-1:0]);
    ok = cfg_write && (sz != 0) && !m_act[t];
    g = -1;
    for (int k = 0; k < F; k++) begin
      f = (m_rr + k) % F;
      if (g < 0 && m_act[f] && in_valid[f] && !out_full[f] && !m_last[f]) g = f;
    end
    rdy = '0;
    if (g >= 0) rdy[g] = 1'b1;
    chk("in_ready", in_ready, rdy);
    for (int k = 0; k < F; k++) m_last[k] = 0;
    if (g >= 0) begin
      w.din  = {TW'(g), in_data[g*DW +: DW]};
      w.done = '0;
      if (m_rem[g] == 1) w.done[g] = 1'b1;
      exp_q.push_back(w);
      m_rem[g]--;
      if (m_rem[g] == 0) m_act[g] = 0;
      m_rr = (g + 1) % F;
      m_last[g] = 1;
    end
    err_q.push_back(cfg_write && !ok);
    if (ok) begin
      m_act[t] = 1;
      m_rem[t] = sz * sz;
    end
  endtask

  // Monitor: pops expectations as the DUT presents writes and cfg errors.
  always @(negedge clk) begin
    if (started) begin
      if (out_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          fail($sformatf("unexpected_write: got out_din=%0h, required no write", out_din));
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("out_din", out_din, e.din);
          chk("flow_done", flow_done, e.done);
        end
        wr_cnt[out_din[TW+DW-1:DW]]++;
        if (prev_wr) cons_cnt++;
      end else begin
        chk("idle_outputs", {flow_done, out_din}, '0);
      end
      prev_wr = (out_write === 1'b1);
      if (cfg_err === 1'b1) err_seen++;
      if (err_q.size() == 0) fail("cfg_err_queue_empty");
      else chk("cfg_err", cfg_err, err_q.pop_front());
    end
  end

  task automatic step(input bit r, input logic [F-1:0] v, input logic [F-1:0] full,
                      input bit cw, input int tag, input int sz);
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = v;
    out_full  = full;
    cfg_write = cw;
    cfg_din   = {TW'(tag), SW'(sz)};
    for (int f = 0; f < F; f++) in_data[f*DW +: DW] = DW'($urandom);
    #3;
    model_cycle();
    #3;
  endtask

  task automatic run_until_idle(input logic [F-1:0] v, input int max, output int cycles);
    cycles = 0;
    do begin
      step(1'b0, v, '0, 1'b0, 0, 0);
      cycles++;
    end while (!(model_idle() && exp_q.size() == 0) && cycles < max);
    if (!(model_idle() && exp_q.size() == 0)) fail($sformatf("drain_timeout after %0d cycles", cycles));
  endtask

  initial begin
    int c, b0, b1, b2, b3, bc, be, guard;
    // Reset state
    step(1'b1, '0, '0, 1'b0, 0, 0);
    started = 1'b1;
    step(1'b1, 4'b1111, '0, 1'b0, 0, 0);
    chk("rst_out_write", out_write, 0);
    chk("rst_out_din", out_din, 0);
    chk("rst_flow_done", flow_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_in_ready", in_ready, 0);

    // Single flow, 23x23, never back-to-back
    b0 = wr_cnt[0]; bc = cons_cnt;
    step(1'b0, 4'b0001, '0, 1'b1, 0, 23);
    run_until_idle(4'b0001, 2000, c);
    chk("s1_writes", wr_cnt[0] - b0, 529);
    chk("s1_consecutive", cons_cnt - bc, 0);

    // Four flows, all valid
    b0 = wr_cnt[0]; b1 = wr_cnt[1]; b2 = wr_cnt[2]; b3 = wr_cnt[3];
    for (int f = 0; f < F; f++) step(1'b0, 4'b1111, '0, 1'b1, f, 23);
    run_until_idle(4'b1111, 3000, c);
    chk("s2_tag0", wr_cnt[0] - b0, 529);
    chk("s2_tag1", wr_cnt[1] - b1, 529);
    chk("s2_tag2", wr_cnt[2] - b2, 529);
    chk("s2_tag3", wr_cnt[3] - b3, 529);
    chk("s2_one_per_cycle", (c + 4) <= 2119, 1);

    // Back-pressure flow 2 for 20 cycles
    for (int f = 0; f < F; f++) step(1'b0, 4'b1111, '0, 1'b1, f, 23);
    for (int i = 0; i < 40; i++) step(1'b0, 4'b1111, '0, 1'b0, 0, 0);
    step(1'b0, 4'b1111, 4'b0100, 1'b0, 0, 0);
    b2 = wr_cnt[2];
    for (int i = 0; i < 19; i++) step(1'b0, 4'b1111, 4'b0100, 1'b0, 0, 0);
    step(1'b0, 4'b1111, '0, 1'b0, 0, 0);
    chk("s4_no_tag2_in_window", wr_cnt[2] - b2, 0);
    b2 = wr_cnt[2];
    run_until_idle(4'b1111, 3000, c);
    chk("s4_tag2_total", wr_cnt[2] - b2 > 0, 1);

    // Rejected configurations
    b1 = wr_cnt[1]; b3 = wr_cnt[3]; be = err_seen;
    step(1'b0, 4'b1111, '0, 1'b1, 1, 23);
    step(1'b0, 4'b1111, '0, 1'b1, 1, 5);
    step(1'b0, 4'b1111, '0, 1'b1, 3, 0);
    run_until_idle(4'b1111, 2000, c);
    chk("s5_cfg_err_count", err_seen - be, 2);
    chk("s5_tag1", wr_cnt[1] - b1, 529);
    chk("s5_tag3", wr_cnt[3] - b3, 0);

    // Reset mid-flow
    b0 = wr_cnt[0];
    step(1'b0, 4'b0001, '0, 1'b1, 0, 23);
    guard = 0;
    while (wr_cnt[0] - b0 < 100 && guard < 400) begin
      step(1'b0, 4'b0001, '0, 1'b0, 0, 0);
      guard++;
    end
    if (wr_cnt[0] - b0 < 100) fail("s6_wait_100_writes timeout");
    step(1'b1, 4'b0001, '0, 1'b0, 0, 0);
    step(1'b0, 4'b1111, '0, 1'b0, 0, 0);
    chk("s6_out_write_after_rst", out_write, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 4'b1111, '0, 1'b0, 0, 0);
    b0 = wr_cnt[0];
    step(1'b0, 4'b0001, '0, 1'b1, 0, 4);
    run_until_idle(4'b0001, 200, c);
    chk("s6_reconfig_writes", wr_cnt[0] - b0, 16);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 300) == 0, F'($urandom), F'($urandom & $urandom),
           ($urandom % 6) == 0, int'($urandom % F), int'($urandom % 6));
    end
    run_until_idle(4'b1111, 500, c);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
